// File: rtl/text_write_ctrl.sv
// Character write controller for the VGA text tile memory.
// Round-robin arbitration of two character streams, cursor, row and screen clears.
module text_write_ctrl #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12,
    parameter int CHAR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [CHAR_W-1:0] a_char,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [CHAR_W-1:0] b_char,
    output logic              b_ready,
    input  logic              clr_req,
    output logic              busy,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [CHAR_W-1:0] wdata,
    output logic [6:0]        cur_col,
    output logic [4:0]        cur_row
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        ROWCLR,
        CLEAR
    } state_t;

    localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(COLS * ROWS - 1);
    localparam logic [6:0]        COL_MAX = 7'(COLS - 1);
    localparam logic [4:0]        ROW_MAX = 5'(ROWS - 1);
    localparam logic [CHAR_W-1:0] C_BS    = CHAR_W'(8);
    localparam logic [CHAR_W-1:0] C_LF    = CHAR_W'(10);
    localparam logic [CHAR_W-1:0] C_CR    = CHAR_W'(13);
    localparam logic [CHAR_W-1:0] C_SP    = CHAR_W'(32);
    localparam logic [CHAR_W-1:0] C_TILDE = CHAR_W'(126);

    state_t              state_q, state_d;
    logic [6:0]          col_q, col_d;
    logic [4:0]          row_q, row_d;
    logic                pend_q, pend_d;
    logic                prio_b_q, prio_b_d;
    logic [CHAR_W-1:0]   char_q, char_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [CHAR_W-1:0]   wdata_q, wdata_d;

    logic                grant_a, grant_b;
    logic [CHAR_W-1:0]   in_char;
    logic [6:0]          bs_col;
    logic [4:0]          bs_row;
    logic [4:0]          row_nx;
    logic                adv;

    function automatic logic [ADDR_W-1:0] lin(input logic [4:0] r,
                                              input logic [6:0] c);
        return ADDR_W'(r) * COLS_A + ADDR_W'(c);
    endfunction

    function automatic logic is_print(input logic [CHAR_W-1:0] c);
        return (c >= C_SP) && (c <= C_TILDE);
    endfunction

    // Grant only in IDLE with no clear pending; ties go to the one not served last.
    always_comb begin
        grant_a = reset && state_q == IDLE && !pend_q && a_valid
                  && (!b_valid || !prio_b_q);
        grant_b = reset && state_q == IDLE && !pend_q && b_valid
                  && (!a_valid || prio_b_q);
        in_char = grant_b ? b_char : a_char;
    end

    // Backspace target position and the row that follows the current one.
    always_comb begin
        bs_col = col_q;
        bs_row = row_q;
        if (col_q != 7'd0) begin
            bs_col = col_q - 7'd1;
        end else if (row_q != 5'd0) begin
            bs_col = COL_MAX;
            bs_row = row_q - 5'd1;
        end
        row_nx = (row_q == ROW_MAX) ? 5'd0 : row_q + 5'd1;
    end

    // Next-state, cursor and registered write-port logic.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        pend_d   = pend_q | clr_req;
        prio_b_d = prio_b_q;
        char_d   = char_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        adv      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = CLEAR;
                    pend_d  = clr_req;
                    we_d    = 1'b1;
                    waddr_d = '0;
                    wdata_d = C_SP;
                end else if (grant_a || grant_b) begin
                    state_d  = WRITE;
                    char_d   = in_char;
                    prio_b_d = grant_a;
                    if (is_print(in_char)) begin
                        we_d    = 1'b1;
                        waddr_d = lin(row_q, col_q);
                        wdata_d = in_char;
                    end else if (in_char == C_BS) begin
                        we_d    = 1'b1;
                        waddr_d = lin(bs_row, bs_col);
                        wdata_d = C_SP;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
                unique case (1'b1)
                    is_print(char_q): begin
                        if (col_q == COL_MAX) adv = 1'b1;
                        else col_d = col_q + 7'd1;
                    end
                    char_q == C_CR: col_d = 7'd0;
                    char_q == C_LF: adv = 1'b1;
                    char_q == C_BS: begin
                        col_d = bs_col;
                        row_d = bs_row;
                    end
                    default: ;
                endcase
                if (adv) begin
                    col_d   = 7'd0;
                    row_d   = row_nx;
                    state_d = ROWCLR;
                    we_d    = 1'b1;
                    waddr_d = lin(row_nx, 7'd0);
                    wdata_d = C_SP;
                end
            end
            ROWCLR: begin
                if (waddr_q == lin(row_q, COL_MAX)) begin
                    state_d = IDLE;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = waddr_q + ADDR_W'(1);
                    wdata_d = C_SP;
                end
            end
            CLEAR: begin
                if (waddr_q == LAST_A) begin
                    state_d = IDLE;
                    col_d   = 7'd0;
                    row_d   = 5'd0;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = waddr_q + ADDR_W'(1);
                    wdata_d = C_SP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, cursor and write-port registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            col_q    <= 7'd0;
            row_q    <= 5'd0;
            pend_q   <= 1'b0;
            prio_b_q <= 1'b0;
            char_q   <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            pend_q   <= pend_d;
            prio_b_q <= prio_b_d;
            char_q   <= char_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign busy    = (state_q != IDLE) || pend_q;
    assign we      = we_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign cur_col = col_q;
    assign cur_row = row_q;

endmodule

// File: tb/tb_text_write_ctrl.sv
// Self-checking bench for text_write_ctrl.
// Behavioural screen model (array + cursor) against captured memory writes.
module tb_text_write_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_valid = 1'b0;
    logic [6:0]  a_char = 7'h0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [6:0]  b_char = 7'h0;
    logic        b_ready;
    logic        clr_req = 1'b0;
    logic        busy;
    logic        we;
    logic [11:0] waddr;
    logic [6:0]  wdata;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;

    always #5 clk = ~clk;

    text_write_ctrl dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_char(a_char), .a_ready(a_ready),
        .b_valid(b_valid), .b_char(b_char), .b_ready(b_ready),
        .clr_req(clr_req), .busy(busy),
        .we(we), .waddr(waddr), .wdata(wdata),
        .cur_col(cur_col), .cur_row(cur_row)
    );

    int total = 0;
    int bad = 0;
    int wcount = 0;
    logic [6:0] s_mem [2400] = '{default: 7'h0};
    logic [6:0] m_mem [2400] = '{default: 7'h0};
    int m_col = 0;
    int m_row = 0;

    // Shadow of the tile memory, captured from the write port.
    always @(negedge clk) begin
        if (reset && we) begin
            if (waddr < 12'd2400) s_mem[waddr] <= wdata;
            wcount <= wcount + 1;
        end
    end

    // ---------------- screen model ----------------
    task automatic model_adv();
        m_col = 0;
        m_row = (m_row == 29) ? 0 : m_row + 1;
        for (int c = 0; c < 80; c++) m_mem[m_row * 80 + c] = 7'h20;
    endtask

    task automatic model_clear();
        for (int a = 0; a < 2400; a++) m_mem[a] = 7'h20;
        m_col = 0;
        m_row = 0;
    endtask

    task automatic model_char(input logic [6:0] c, output bit ew,
                              output int ea, output logic [6:0] ed);
        ew = 0; ea = 0; ed = 7'h0;
        if (c >= 7'h20 && c <= 7'h7E) begin
            ew = 1; ea = m_row * 80 + m_col; ed = c;
            m_mem[ea] = c;
            if (m_col == 79) model_adv();
            else m_col++;
        end else if (c == 7'h0D) begin
            m_col = 0;
        end else if (c == 7'h0A) begin
            model_adv();
        end else if (c == 7'h08) begin
            if (m_col > 0) m_col--;
            else if (m_row > 0) begin m_col = 79; m_row--; end
            ew = 1; ea = m_row * 80 + m_col; ed = 7'h20;
            m_mem[ea] = 7'h20;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send(input bit use_b, input logic [6:0] c, output bit ok);
        @(posedge clk); #1;
        if (use_b) begin b_valid = 1'b1; b_char = c; end
        else begin a_valid = 1'b1; a_char = c; end
        ok = 0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (use_b ? b_ready : a_ready) ok = 1;
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL send_timeout code=%h never accepted", c);
        end
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL wait_idle busy=%b stayed high, required 0", busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b0; clr_req = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; a_char = 7'h41; b_char = 7'h42;
        #2;
        total++;
        if ({we, waddr, wdata, cur_col, cur_row, busy, a_ready, b_ready} !== 35'd0) begin
            bad++;
            $display("FAIL reset_async we=%b addr=%0d data=%h col=%0d row=%0d busy=%b ar=%b br=%b, required all 0",
                     we, waddr, wdata, cur_col, cur_row, busy, a_ready, b_ready);
        end
        repeat (2) @(negedge clk);
        total++;
        if ({we, waddr, wdata, cur_col, cur_row, busy, a_ready, b_ready} !== 35'd0) begin
            bad++;
            $display("FAIL reset_hold we=%b addr=%0d col=%0d row=%0d busy=%b ar=%b br=%b, required all 0",
                     we, waddr, cur_col, cur_row, busy, a_ready, b_ready);
        end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0; reset = 1'b1;
        m_col = 0; m_row = 0;
    endtask

    task automatic test_single();
        bit ok; bit ew; int ea; logic [6:0] ed; int w0;
        send(0, 7'h41, ok);
        model_char(7'h41, ew, ea, ed);
        w0 = wcount;
        @(negedge clk);
        total++;
        if ({we, waddr, wdata} !== {1'b1, 12'd0, 7'h41}) begin
            bad++;
            $display("FAIL single_write we=%b addr=%0d data=%h, required 1/0/41", we, waddr, wdata);
        end
        @(negedge clk);
        total++;
        if ({we, busy, cur_col, cur_row} !== {1'b0, 1'b0, 7'd1, 5'd0}) begin
            bad++;
            $display("FAIL single_after we=%b busy=%b cursor=(%0d,%0d), required 0/0/(1,0)",
                     we, busy, cur_col, cur_row);
        end
        @(posedge clk); #1;
        total++;
        if (wcount - w0 != 1) begin
            bad++;
            $display("FAIL single_count writes=%0d, required 1", wcount - w0);
        end
    endtask

    task automatic test_rr();
        bit ew; int ea; logic [6:0] ed;
        string seq = "";
        int last = -1; int gap_bad = 0; int both = 0; int n = 0;
        test_reset();
        @(posedge clk); #1;
        a_valid = 1'b1; b_valid = 1'b1; a_char = 7'h41; b_char = 7'h42;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (a_ready && b_ready) both++;
            if (a_ready || b_ready) begin
                if (a_ready) begin seq = {seq, "A"}; model_char(7'h41, ew, ea, ed); end
                else begin seq = {seq, "B"}; model_char(7'h42, ew, ea, ed); end
                if (last >= 0 && i - last != 2) gap_bad++;
                last = i;
                n++;
            end
        end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        total++;
        if (seq != "ABAB") begin
            bad++;
            $display("FAIL rr_order got %s, required ABAB", seq);
        end
        total++;
        if (both != 0 || gap_bad != 0) begin
            bad++;
            $display("FAIL rr_timing both_ready=%0d bad_gaps=%0d, required 0/0", both, gap_bad);
        end
        wait_idle();
        total++;
        if ({s_mem[0], s_mem[1], s_mem[2], s_mem[3]} !== {7'h41, 7'h42, 7'h41, 7'h42}) begin
            bad++;
            $display("FAIL rr_mem got %h %h %h %h, required 41 42 41 42",
                     s_mem[0], s_mem[1], s_mem[2], s_mem[3]);
        end
    endtask

    task automatic test_wrap();
        bit ok; bit ew; int ea; logic [6:0] ed; logic [6:0] c;
        test_reset();
        for (int i = 0; i < 79; i++) begin
            c = 7'($urandom_range(33, 126));
            send(0, c, ok);
            model_char(c, ew, ea, ed);
            wait_idle();
        end
        c = 7'h5A;
        send(0, c, ok);
        model_char(c, ew, ea, ed);
        a_valid = 1'b1; a_char = 7'h07;
        @(negedge clk);
        total++;
        if ({we, waddr, wdata} !== {1'b1, 12'd79, c}) begin
            bad++;
            $display("FAIL wrap_last we=%b addr=%0d data=%h, required 1/79/5a", we, waddr, wdata);
        end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            total++;
            if ({we, waddr, wdata, a_ready, busy} !== {1'b1, 12'(80 + i), 7'h20, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL rowclr_cycle%0d we=%b addr=%0d data=%h ar=%b busy=%b, required 1/%0d/20/0/1",
                         i, we, waddr, wdata, a_ready, busy, 80 + i);
            end
            if (i == 0) begin
                total++;
                if ({cur_col, cur_row} !== {7'd0, 5'd1}) begin
                    bad++;
                    $display("FAIL wrap_cursor got (%0d,%0d), required (0,1)", cur_col, cur_row);
                end
            end
        end
        @(negedge clk);
        total++;
        if ({we, a_ready} !== 2'b01) begin
            bad++;
            $display("FAIL rowclr_end we=%b ar=%b, required 0/1", we, a_ready);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        model_char(7'h07, ew, ea, ed);
        wait_idle();
    endtask

    task automatic test_bs();
        bit ok; bit ew; int ea; logic [6:0] ed;
        send(0, 7'h08, ok);
        model_char(7'h08, ew, ea, ed);
        @(negedge clk);
        total++;
        if ({we, waddr, wdata} !== {1'b1, 12'd79, 7'h20}) begin
            bad++;
            $display("FAIL bs_wrap_write we=%b addr=%0d data=%h, required 1/79/20", we, waddr, wdata);
        end
        wait_idle();
        total++;
        if ({cur_col, cur_row} !== {7'd79, 5'd0}) begin
            bad++;
            $display("FAIL bs_wrap_cursor got (%0d,%0d), required (79,0)", cur_col, cur_row);
        end
        send(1, 7'h0D, ok);
        model_char(7'h0D, ew, ea, ed);
        wait_idle();
        send(0, 7'h08, ok);
        model_char(7'h08, ew, ea, ed);
        @(negedge clk);
        total++;
        if ({we, waddr, wdata} !== {1'b1, 12'd0, 7'h20}) begin
            bad++;
            $display("FAIL bs_origin_write we=%b addr=%0d data=%h, required 1/0/20", we, waddr, wdata);
        end
        wait_idle();
        total++;
        if ({cur_col, cur_row} !== {7'd0, 5'd0}) begin
            bad++;
            $display("FAIL bs_origin_cursor got (%0d,%0d), required (0,0)", cur_col, cur_row);
        end
    endtask

    task automatic test_lf_wrap();
        bit ok; bit ew; int ea; logic [6:0] ed; int w0;
        for (int i = 0; i < 29; i++) begin
            send(0, 7'h0A, ok);
            model_char(7'h0A, ew, ea, ed);
            wait_idle();
        end
        for (int i = 0; i < 5; i++) begin
            send(1, 7'(7'h61 + i), ok);
            model_char(7'(7'h61 + i), ew, ea, ed);
            wait_idle();
        end
        total++;
        if ({cur_col, cur_row} !== {7'd5, 5'd29}) begin
            bad++;
            $display("FAIL lf_setup_cursor got (%0d,%0d), required (5,29)", cur_col, cur_row);
        end
        send(0, 7'h0A, ok);
        model_char(7'h0A, ew, ea, ed);
        @(negedge clk);
        total++;
        if (we !== 1'b0) begin
            bad++;
            $display("FAIL lf_nowrite we=%b, required 0", we);
        end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            total++;
            if ({we, waddr, wdata} !== {1'b1, 12'(i), 7'h20}) begin
                bad++;
                $display("FAIL lf_rowclr%0d we=%b addr=%0d data=%h, required 1/%0d/20",
                         i, we, waddr, wdata, i);
            end
        end
        wait_idle();
        total++;
        if ({cur_col, cur_row} !== {7'd0, 5'd0}) begin
            bad++;
            $display("FAIL lf_wrap_cursor got (%0d,%0d), required (0,0)", cur_col, cur_row);
        end
        send(0, 7'h07, ok);
        model_char(7'h07, ew, ea, ed);
        w0 = wcount;
        wait_idle();
        @(posedge clk); #1;
        total++;
        if (wcount != w0 || {cur_col, cur_row} !== {7'd0, 5'd0}) begin
            bad++;
            $display("FAIL discard writes=%0d cursor=(%0d,%0d), required 0 and (0,0)",
                     wcount - w0, cur_col, cur_row);
        end
    endtask

    task automatic test_clear();
        bit ok; bit ew; int ea; logic [6:0] ed; int mism = 0;
        send(0, 7'h78, ok); model_char(7'h78, ew, ea, ed); wait_idle();
        send(1, 7'h79, ok); model_char(7'h79, ew, ea, ed); wait_idle();
        @(posedge clk); #1;
        clr_req = 1'b1;
        @(negedge clk);
        total++;
        if ({we, busy} !== 2'b00) begin
            bad++;
            $display("FAIL clear_m we=%b busy=%b, required 0/0", we, busy);
        end
        @(posedge clk); #1;
        clr_req = 1'b0;
        @(negedge clk);
        total++;
        if ({we, busy} !== 2'b01) begin
            bad++;
            $display("FAIL clear_m1 we=%b busy=%b, required 0/1", we, busy);
        end
        for (int i = 0; i < 2400; i++) begin
            @(negedge clk);
            if ({we, waddr, wdata} !== {1'b1, 12'(i), 7'h20}) mism++;
        end
        total++;
        if (mism != 0) begin
            bad++;
            $display("FAIL clear_seq bad_cycles=%0d, required 0", mism);
        end
        @(negedge clk);
        total++;
        if ({we, busy, cur_col, cur_row} !== 14'd0) begin
            bad++;
            $display("FAIL clear_done we=%b busy=%b cursor=(%0d,%0d), required 0/0/(0,0)",
                     we, busy, cur_col, cur_row);
        end
        model_clear();
    endtask

    task automatic test_clr_in_rowclr();
        bit ok; bit ew; int ea; logic [6:0] ed;
        int idx = 0; int mism = 0; int ex; bit done = 0;
        send(0, 7'h0A, ok);
        model_char(7'h0A, ew, ea, ed);
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk); #1;
            clr_req = (i == 10);
            @(negedge clk);
            if (we) begin
                ex = (idx < 80) ? 80 + idx : idx - 80;
                if ({waddr, wdata} !== {12'(ex), 7'h20}) mism++;
                idx++;
            end
            if (!busy) done = 1;
        end
        clr_req = 1'b0;
        model_clear();
        total++;
        if (!done || mism != 0 || idx != 2480) begin
            bad++;
            $display("FAIL clr_in_rowclr done=%b bad=%0d writes=%0d, required 1/0/2480", done, mism, idx);
        end
        total++;
        if ({cur_col, cur_row} !== {7'd0, 5'd0}) begin
            bad++;
            $display("FAIL clr_in_rowclr_cursor got (%0d,%0d), required (0,0)", cur_col, cur_row);
        end
    endtask

    task automatic test_random();
        bit ok; bit ew; int ea; logic [6:0] ed; logic [6:0] c; bit ub; int mism = 0;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0: c = 7'h0D;
                1: c = 7'h0A;
                2: c = 7'h08;
                3: c = 7'($urandom_range(0, 31));
                default: c = 7'($urandom_range(32, 126));
            endcase
            ub = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send(ub, c, ok);
            model_char(c, ew, ea, ed);
            @(negedge clk);
            total++;
            if (ew ? ({we, waddr, wdata} !== {1'b1, 12'(ea), ed}) : (we !== 1'b0)) begin
                bad++;
                $display("FAIL rand_write%0d code=%h we=%b addr=%0d data=%h, required we=%b addr=%0d data=%h",
                         n, c, we, waddr, wdata, ew, ea, ed);
            end
            wait_idle();
        end
        total++;
        if ({cur_col, cur_row} !== {7'(m_col), 5'(m_row)}) begin
            bad++;
            $display("FAIL rand_cursor got (%0d,%0d), required (%0d,%0d)", cur_col, cur_row, m_col, m_row);
        end
        for (int a = 0; a < 2400; a++) if (s_mem[a] !== m_mem[a]) mism++;
        total++;
        if (mism != 0) begin
            bad++;
            $display("FAIL rand_memory differing_cells=%0d, required 0", mism);
        end
    endtask

    task automatic test_reset_mid_clear();
        @(posedge clk); #1;
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (300) @(negedge clk);
        total++;
        if ({we, busy} !== 2'b11) begin
            bad++;
            $display("FAIL midclear_active we=%b busy=%b, required 1/1", we, busy);
        end
        #2;
        reset = 1'b0;
        a_valid = 1'b1; a_char = 7'h41;
        #1;
        total++;
        if ({we, waddr, wdata, cur_col, cur_row, busy, a_ready, b_ready} !== 35'd0) begin
            bad++;
            $display("FAIL midclear_reset we=%b addr=%0d data=%h busy=%b ar=%b, required all 0",
                     we, waddr, wdata, busy, a_ready);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({we, busy} !== 2'b00) begin
            bad++;
            $display("FAIL midclear_after we=%b busy=%b, required 0/0", we, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_wrap();
        test_bs();
        test_lf_wrap();
        test_clear();
        test_clr_in_rowclr();
        test_random();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/text_write_ctrl.md
# text_write_ctrl

Character-write controller that sits between input requesters (switch/button entry, serial receiver) and the write port of the character tile memory read by the text generation circuit behind the VGA controller. It arbitrates two valid/ready character streams round-robin and maintains a text cursor. It interprets control codes and issues one memory write per character. It also sequences full-screen clears and single-row clears, one address per clock.

## Interface
- COLS, 80, characters per row (640 px / 8 px glyph)
- ROWS, 30, rows per screen (480 px / 16 px glyph)
- ADDR_W, 12, tile memory address width; must satisfy 2^ADDR_W >= COLS*ROWS
- CHAR_W, 7, character code width (7-bit ASCII)

Ports:
- clk  in  1  system clock (100 MHz); the only clock
- reset  in  1  asynchronous, active-low reset
- a_valid  in  1  requester A has a character
- a_char  in  CHAR_W  requester A character code
- a_ready  out  1  controller accepts A this cycle
- b_valid  in  1  requester B has a character
- b_char  in  CHAR_W  requester B character code
- b_ready  out  1  controller accepts B this cycle
- clr_req  in  1  single-cycle pulse: clear whole screen
- busy  out  1  controller not in IDLE, or a clear is pending
- we  out  1  tile memory write enable
- waddr  out  ADDR_W  tile memory address = row*COLS + col
- wdata  out  CHAR_W  tile memory write data
- cur_col  out  7  cursor column, 0..COLS-1
- cur_row  out  5  cursor row, 0..ROWS-1

## Operation
- States: IDLE, WRITE, ROWCLR, CLEAR.
- clr_req sets clr_pend in any state. In IDLE, clr_pend has priority over character requests: go to CLEAR, clear clr_pend, and hold a_ready = b_ready = 0.
- IDLE grant, combinational: if exactly one valid, grant it. If both valid, grant the requester not granted last; the pointer starts at A after reset. A transfer is valid&ready. Ready is 0 in every non-IDLE state.
- Accepted code, handled in WRITE:
  - 0x20-0x7E: we=1, wdata=code at the cursor, then col+1.
  - 0x0D (CR): col=0, no write.
  - 0x0A (LF): col=0 and advance row.
  - 0x08 (BS): if col>0, col-1; else if row>0, col=COLS-1 and row-1; else stay at (0,0). In all cases write 0x20 at the new cursor position.
  - Other codes: accepted and discarded, no write.
- Column wrap: printable write at col=COLS-1 advances the row.
- Row advance: row+1, or 0 when row=ROWS-1. Set col=0, then enter ROWCLR for the new row.
- ROWCLR: write 0x20 to row*COLS+0 .. row*COLS+COLS-1, one per cycle, then return to IDLE.
- CLEAR: write 0x20 to addresses 0 .. COLS*ROWS-1, one per cycle, then set cursor (0,0) and return to IDLE.
- clr_req during ROWCLR or WRITE: the current operation completes, then CLEAR starts from IDLE. clr_req during CLEAR: clr_pend is set, so a second full clear follows.
- Arithmetic: row*COLS+col is computed at ADDR_W bits and never exceeds COLS*ROWS-1.

## Timing
- Reset (asynchronous, reset=0): state=IDLE, we=0, waddr=0, wdata=0, cur_col=0, cur_row=0, busy=0, clr_pend=0, rr pointer=A, a_ready=b_ready=0.
- Reset asserted mid-CLEAR or mid-ROWCLR aborts the operation immediately. Memory contents are left partially cleared.
- we, waddr and wdata are registered.
- Character accepted in cycle N (IDLE): WRITE in N+1 with we=1 for printables; cursor updated at end of N+1.
- If no row advance occurs, IDLE resumes in N+2. Peak throughput is 1 character per 2 cycles.
- Row advance: ROWCLR occupies N+2 .. N+1+COLS; IDLE resumes in N+2+COLS.
- clr_req in cycle M while IDLE with no request: CLEAR writes occupy M+2 .. M+1+COLS*ROWS (2400 cycles default); IDLE and cursor (0,0) follow in the next cycle.
- busy is high from the cycle after a transfer or clr_req until the cycle state returns to IDLE with clr_pend=0.
- a_ready and b_ready are never high in the same cycle.

## Test plan
- Reset, then A sends 0x41: we=1, waddr=0, wdata=0x41 in the cycle after acceptance; cursor goes to (1,0); exactly one write.
- A and B both valid continuously with 0x41/0x42: grants alternate A,B,A,B; memory addresses 0..3 hold 41,42,41,42.
- 80 printables from row 0: the 80th lands at addr 79; then cursor (0,1); ROWCLR writes 0x20 to addrs 80..159 over 80 cycles; ready=0 throughout.
- Cursor (0,1), send 0x08: cursor becomes (79,0) and 0x20 is written at addr 79. Cursor (0,0), send 0x08: 0x20 written at addr 0, cursor stays (0,0).
- Cursor (5,29), send 0x0A: cursor becomes (0,0) and ROWCLR covers addrs 0..79. Send 0x07: accepted, no we pulse, cursor unchanged.
- clr_req pulse during ROWCLR: ROWCLR finishes, then 2400 writes of 0x20 at addrs 0..2399, then cursor (0,0) and busy=0. Assert reset mid-CLEAR: we drops immediately and all outputs return to their reset values.
